// File: rtl/nibble_serializer_pkg.sv
// rtl/nibble_serializer_pkg.sv - shared types, constants and nibble ordering helper
package nibble_serializer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Position of the cnt-th emitted nibble inside the packed word.
    function automatic int nib_idx(input int cnt, input bit msb_first, input int width);
        return msb_first ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// rtl/nibble_serializer_if.sv - packed-word input and nibble output stream bundle
interface nibble_serializer_if #(
    parameter int WIDTH = 8
);
    import nibble_serializer_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    logic [WIDTH-1:0][NIBBLE_W-1:0]     in0;
    logic                               out_valid;
    logic                               out_ready;
    logic [NIBBLE_W-1:0]                out;
    logic                               out_last;

    modport master (
        output in_valid, in0, out_ready,
        input  in_ready, out_valid, out, out_last
    );

    modport slave (
        input  in_valid, in0, out_ready,
        output in_ready, out_valid, out, out_last
    );

endinterface

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - packed nibble word to 4-bit valid/ready stream
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    nibble_serializer_if.slave  bus
);

    localparam int CW    = $clog2(WIDTH);
    localparam int FIRST = nib_idx(0, MSB_FIRST, WIDTH);

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [CW-1:0]                  cnt_next;
    logic [CW-1:0]                  idx_next;
    logic [WIDTH-1:0][NIBBLE_W-1:0] shadow;
    logic [NIBBLE_W-1:0]            out_q;
    logic                           valid_q;
    logic                           last_q;
    logic                           accept;
    logic                           xfer;

    // A new word may enter while the last nibble of the old one is leaving.
    assign bus.in_ready  = !reset && (state == IDLE || (last_q && bus.out_ready));
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = valid_q && bus.out_ready;

    always_comb begin
        cnt_next = cnt + 1'b1;
        idx_next = CW'(nib_idx(int'(cnt_next), MSB_FIRST, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shadow  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            cnt     <= '0;
            shadow  <= bus.in0;
            out_q   <= bus.in0[FIRST];
            valid_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (xfer) begin
            if (last_q) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                // cnt stops at WIDTH-1 because last_q blocks further increments.
                cnt     <= cnt_next;
                out_q   <= shadow[idx_next];
                last_q  <= (cnt_next == CW'(WIDTH - 1));
            end
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - randomized and directed bench against a nibble queue model
module tb_nibble_serializer;
    import nibble_serializer_pkg::*;

    localparam int W = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic [W-1:0][3:0]    in0 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int rdy_seen = 0;
    logic [63:0] cap_m, cap_l;
    logic [3:0]  qm[$];
    logic [3:0]  ql[$];

    always #5 clk = ~clk;

    nibble_serializer_if #(.WIDTH(W)) bm ();
    nibble_serializer_if #(.WIDTH(W)) bl ();

    assign bm.in_valid  = in_valid;
    assign bm.in0       = in0;
    assign bm.out_ready = out_ready;
    assign bl.in_valid  = in_valid;
    assign bl.in0       = in0;
    assign bl.out_ready = out_ready;

    nibble_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(bm));
    nibble_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(bl));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mdl_ready();
        return !reset && (qm.size() == 0 || (qm.size() == 1 && out_ready));
    endfunction

    task automatic check_cycle();
        check("in_ready_msb", 64'(bm.in_ready), 64'(mdl_ready()));
        check("in_ready_lsb", 64'(bl.in_ready), 64'(mdl_ready()));
        check("valid_msb", 64'(bm.out_valid), 64'(qm.size() != 0));
        check("valid_lsb", 64'(bl.out_valid), 64'(ql.size() != 0));
        if (qm.size() != 0) begin
            check("out_msb", 64'(bm.out), 64'(qm[0]));
            check("last_msb", 64'(bm.out_last), 64'(qm.size() == 1));
        end
        if (ql.size() != 0) begin
            check("out_lsb", 64'(bl.out), 64'(ql[0]));
            check("last_lsb", 64'(bl.out_last), 64'(ql.size() == 1));
        end
    endtask

    // Advance one clock and apply the same edge to the model queues.
    task automatic tick();
        bit rst, acc, xfr;
        logic [W-1:0][3:0] w;
        rst = reset;
        acc = in_valid && mdl_ready();
        xfr = (qm.size() != 0) && out_ready;
        w   = in0;
        @(posedge clk);
        if (rst) begin
            qm.delete();
            ql.delete();
        end else begin
            if (xfr) begin
                cap_m = {cap_m[59:0], qm.pop_front()};
                cap_l = {cap_l[59:0], ql.pop_front()};
                n_xfer++;
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(w[W-1-i]);
                    ql.push_back(w[i]);
                end
            end
        end
        #1;
    endtask

    task automatic cycle(input bit v, input logic [31:0] w, input bit r);
        in_valid  = v;
        in0       = w;
        out_ready = r;
        #1;
        check_cycle();
        rdy_seen += int'(bm.in_ready);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && qm.size() != 0; i++) cycle(1'b0, 32'h0, 1'b1);
        check("drain_done", 64'(qm.size()), 64'd0);
    endtask

    initial begin
        // Reset held with in_valid asserted
        in_valid = 1'b1;
        in0 = 32'h12345678;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_out", 64'(bm.out), 64'h0);
            check("rst_valid", 64'(bm.out_valid), 64'h0);
            cycle(1'b1, 32'h12345678, 1'b1);
        end
        reset = 1'b0;
        #1;
        check("rst_release_rdy", 64'(bm.in_ready), 64'h1);
        cycle(1'b0, 32'h0, 1'b1);

        // Single word, both orders
        cap_m = '0; cap_l = '0; n_xfer = 0;
        cycle(1'b1, 32'h76543210, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        check("single_msb", cap_m, 64'h76543210);
        check("single_lsb", cap_l, 64'h01234567);
        check("single_xfers", 64'(n_xfer), 64'd8);

        // Back-pressure with alternating out_ready
        cap_m = '0; cap_l = '0; n_xfer = 0;
        cycle(1'b1, 32'h76543210, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, (i % 2) == 0);
        check("bp_msb", cap_m, 64'h76543210);
        check("bp_xfers", 64'(n_xfer), 64'd8);
        drain();

        // Back-to-back words
        cap_m = '0; cap_l = '0; n_xfer = 0;
        cycle(1'b1, 32'hFEDCBA98, 1'b1);
        rdy_seen = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h01234567, 1'b1);
        check("b2b_rdy_count", 64'(rdy_seen), 64'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        check("b2b_msb", cap_m, 64'hFEDCBA9801234567);
        check("b2b_lsb", cap_l, 64'h89ABCDEF76543210);
        check("b2b_xfers", 64'(n_xfer), 64'd16);

        // Reset mid-word
        cycle(1'b1, 32'h76543210, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_valid", 64'(bm.out_valid), 64'h0);
        cap_m = '0; cap_l = '0;
        cycle(1'b1, 32'hA5A5A5A5, 1'b1);
        drain();
        check("midrst_msb", cap_m, 64'hA5A5A5A5);
        check("midrst_lsb", cap_l, 64'h5A5A5A5A);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) != 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
